zbuf_sequencer: RTL and testbench

ZBUF_SEQUENCER -- requirements
Module: zbuf_sequencer

---
 rtl/zbuf_pkg.sv | 33 +++
 rtl/zbuf_sequencer_fifo.sv | 63 ++++++
 rtl/zbuf_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_zbuf_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbuf_pkg.sv
// Types shared by the z-buffer sequencer and the z_buffer itself.
// Holds the sequencer FSM states, depth-compare functions and counter helpers.
package zbuf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_WAIT,
        S_OUT,
        S_FLUSH,
        S_FLUSH_WAIT
    } seq_state_e;

    // Compare function selected inside z_buffer; the sequencer only forwards fragments.
    typedef enum logic [2:0] {
        DF_NEVER,
        DF_LESS,
        DF_EQUAL,
        DF_LEQUAL,
        DF_GREATER,
        DF_NOTEQUAL,
        DF_GEQUAL,
        DF_ALWAYS
    } depth_func_e;

    localparam int CNT_W = 16;

    // Statistics counters roll over from all-ones back to zero.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/zbuf_sequencer_fifo.sv
// Fragment queue: synchronous FIFO with a registered read port.
// The read register doubles as the sequencer's hold register for the fragment under test.
module frag_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/zbuf_sequencer.sv
// Sequences queued fragments through an external z_buffer, forwards passing fragments,
// and orders depth-buffer clears behind all fragments queued before the clear request.
module zbuf_sequencer
    import zbuf_pkg::*;
#(
    parameter int Z_SIZE       = 8,
    parameter int X_PIXEL_SIZE = 2,
    parameter int Y_PIXEL_SIZE = 2,
    parameter int COLOR_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [COLOR_SIZE-1:0]   frag_color_i,
    input  logic                    flush_req_i,
    output logic                    flush_ack_o,
    output logic                    zb_start_o,
    output logic                    zb_flush_o,
    output logic [X_PIXEL_SIZE-1:0] zb_x_o,
    output logic [Y_PIXEL_SIZE-1:0] zb_y_o,
    output logic [Z_SIZE-1:0]       zb_z_o,
    input  logic                    zb_done_i,
    input  logic                    zb_depth_pass_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [X_PIXEL_SIZE-1:0] out_x_o,
    output logic [Y_PIXEL_SIZE-1:0] out_y_o,
    output logic [COLOR_SIZE-1:0]   out_color_o,
    output logic [CNT_W-1:0]        pass_cnt_o,
    output logic [CNT_W-1:0]        kill_cnt_o
);

    localparam int ENTRY_W = X_PIXEL_SIZE + Y_PIXEL_SIZE + Z_SIZE + COLOR_SIZE;
    localparam int Z_LSB   = COLOR_SIZE;
    localparam int Y_LSB   = COLOR_SIZE + Z_SIZE;
    localparam int X_LSB   = COLOR_SIZE + Z_SIZE + Y_PIXEL_SIZE;

    seq_state_e       state_reg, state_next;
    logic             flush_pending_reg;
    logic             run_reg;
    logic             zb_start_reg;
    logic             zb_flush_reg;
    logic             flush_ack_reg, flush_ack_next;
    logic [CNT_W-1:0] pass_cnt_reg;
    logic [CNT_W-1:0] kill_cnt_reg;
    logic             pass_inc, kill_inc;

    logic               fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] hold;

    logic [X_PIXEL_SIZE-1:0] hold_x;
    logic [Y_PIXEL_SIZE-1:0] hold_y;
    logic [Z_SIZE-1:0]       hold_z;
    logic [COLOR_SIZE-1:0]   hold_color;

    // run_reg keeps the input closed during reset and for the first edge after it.
    assign frag_ready_o = run_reg && !fifo_full && !flush_pending_reg;
    assign fifo_push    = frag_valid_i && frag_ready_o;
    assign fifo_wr_data = {frag_x_i, frag_y_i, frag_z_i, frag_color_i};

    frag_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .srst    (rst_i),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr_data),
        .rd_data (hold),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign hold_color = hold[COLOR_SIZE-1:0];
    assign hold_z     = hold[Z_LSB +: Z_SIZE];
    assign hold_y     = hold[Y_LSB +: Y_PIXEL_SIZE];
    assign hold_x     = hold[X_LSB +: X_PIXEL_SIZE];

    always_comb begin
        state_next     = state_reg;
        fifo_pop       = 1'b0;
        flush_ack_next = 1'b0;
        pass_inc       = 1'b0;
        kill_inc       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Fragments already queued drain before a pending clear is issued.
                if (flush_pending_reg && fifo_empty) begin
                    state_next = S_FLUSH;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_TEST;
                end
            end
            S_TEST: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (zb_done_i) begin
                    if (zb_depth_pass_i) begin
                        pass_inc   = 1'b1;
                        state_next = S_OUT;
                    end else begin
                        kill_inc   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                state_next = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                if (zb_done_i) begin
                    flush_ack_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= S_IDLE;
            run_reg           <= 1'b0;
            flush_pending_reg <= 1'b0;
            zb_start_reg      <= 1'b0;
            zb_flush_reg      <= 1'b0;
            flush_ack_reg     <= 1'b0;
            pass_cnt_reg      <= '0;
            kill_cnt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= 1'b1;
            zb_start_reg  <= (state_next == S_TEST) || (state_next == S_FLUSH);
            zb_flush_reg  <= (state_next == S_FLUSH);
            flush_ack_reg <= flush_ack_next;
            if (flush_ack_next) begin
                flush_pending_reg <= 1'b0;
            end else if (flush_req_i) begin
                flush_pending_reg <= 1'b1;
            end
            if (pass_inc) begin
                pass_cnt_reg <= cnt_inc(pass_cnt_reg);
            end
            if (kill_inc) begin
                kill_cnt_reg <= cnt_inc(kill_cnt_reg);
            end
        end
    end

    assign zb_start_o  = zb_start_reg;
    assign zb_flush_o  = zb_flush_reg;
    assign flush_ack_o = flush_ack_reg;
    assign zb_x_o      = hold_x;
    assign zb_y_o      = hold_y;
    assign zb_z_o      = hold_z;
    assign out_valid_o = (state_reg == S_OUT);
    assign out_x_o     = hold_x;
    assign out_y_o     = hold_y;
    assign out_color_o = hold_color;
    assign pass_cnt_o  = pass_cnt_reg;
    assign kill_cnt_o  = kill_cnt_reg;

endmodule

// File: tb/tb_zbuf_sequencer.sv
// Directed bench for zbuf_sequencer: latency, pass/kill, back-pressure, flush barrier, reset abort.
module tb_zbuf_sequencer;

    logic        clk;
    logic        rst;
    logic        frag_valid;
    logic        frag_ready;
    logic [1:0]  frag_x, frag_y;
    logic [7:0]  frag_z;
    logic [15:0] frag_color;
    logic        flush_req, flush_ack;
    logic        zb_start, zb_flush;
    logic [1:0]  zb_x, zb_y;
    logic [7:0]  zb_z;
    logic        zb_done, zb_pass;
    logic        out_valid, out_ready;
    logic [1:0]  out_x, out_y;
    logic [15:0] out_color;
    logic [15:0] pass_cnt, kill_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_pass = 0;
    int exp_kill = 0;

    zbuf_sequencer #(
        .Z_SIZE       (8),
        .X_PIXEL_SIZE (2),
        .Y_PIXEL_SIZE (2),
        .COLOR_SIZE   (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .frag_valid_i    (frag_valid),
        .frag_ready_o    (frag_ready),
        .frag_x_i        (frag_x),
        .frag_y_i        (frag_y),
        .frag_z_i        (frag_z),
        .frag_color_i    (frag_color),
        .flush_req_i     (flush_req),
        .flush_ack_o     (flush_ack),
        .zb_start_o      (zb_start),
        .zb_flush_o      (zb_flush),
        .zb_x_o          (zb_x),
        .zb_y_o          (zb_y),
        .zb_z_o          (zb_z),
        .zb_done_i       (zb_done),
        .zb_depth_pass_i (zb_pass),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_x_o         (out_x),
        .out_y_o         (out_y),
        .out_color_o     (out_color),
        .pass_cnt_o      (pass_cnt),
        .kill_cnt_o      (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic set_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                            input logic [15:0] c);
        frag_x     = x;
        frag_y     = y;
        frag_z     = z;
        frag_color = c;
        frag_valid = 1'b1;
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (zb_start !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_start"}, zb_start, 1);
    endtask

    // Drives one queued fragment through test and, if it passes, through the output handshake.
    task automatic run_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                            input logic [15:0] c, input bit pass, input string tag);
        wait_start(tag);
        chk({tag, "_flush_lo"}, zb_flush, 0);
        chk({tag, "_zb_x"}, zb_x, x);
        chk({tag, "_zb_y"}, zb_y, y);
        chk({tag, "_zb_z"}, zb_z, z);
        step();
        chk({tag, "_start_1cyc"}, zb_start, 0);
        zb_done = 1'b1;
        zb_pass = pass;
        step();
        zb_done = 1'b0;
        zb_pass = 1'b0;
        if (pass) begin
            exp_pass++;
            chk({tag, "_out_valid"}, out_valid, 1);
            chk({tag, "_out_x"}, out_x, x);
            chk({tag, "_out_y"}, out_y, y);
            chk({tag, "_out_col"}, out_color, c);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk({tag, "_out_done"}, out_valid, 0);
        end else begin
            exp_kill++;
            chk({tag, "_no_out"}, out_valid, 0);
        end
        chk({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        chk({tag, "_kill_cnt"}, kill_cnt, exp_kill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        frag_valid = 1'b0;
        frag_x     = '0;
        frag_y     = '0;
        frag_z     = '0;
        frag_color = '0;
        flush_req  = 1'b0;
        zb_done    = 1'b0;
        zb_pass    = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", frag_ready, 0);
        chk("rst_start", zb_start, 0);
        chk("rst_flush", zb_flush, 0);
        chk("rst_ack", flush_ack, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_kill_cnt", kill_cnt, 0);
        chk("rst_zb_z", zb_z, 0);
        chk("rst_out_col", out_color, 0);
        rst = 1'b0;
        chk("ready_at_rst_fall", frag_ready, 0);
        step();
        chk("ready_after_rst", frag_ready, 1);

        // Passing fragment, minimum latency, done ignored in S_OUT
        set_frag(2'd1, 2'd2, 8'h40, 16'hBEEF);
        chk("p_ready", frag_ready, 1);
        step();
        frag_valid = 1'b0;
        chk("lat_n1_start", zb_start, 0);
        step();
        chk("lat_n2_start", zb_start, 1);
        chk("lat_n2_flush", zb_flush, 0);
        chk("p_zb_x", zb_x, 1);
        chk("p_zb_y", zb_y, 2);
        chk("p_zb_z", zb_z, 8'h40);
        step();
        chk("p_start_1cyc", zb_start, 0);
        zb_done = 1'b1;
        zb_pass = 1'b1;
        step();
        exp_pass++;
        zb_pass = 1'b0;
        chk("p_out_valid", out_valid, 1);
        chk("p_out_x", out_x, 1);
        chk("p_out_y", out_y, 2);
        chk("p_out_col", out_color, 16'hBEEF);
        chk("p_pass_cnt", pass_cnt, 1);
        step();
        zb_done = 1'b0;
        chk("p_done_ignored_valid", out_valid, 1);
        chk("p_done_ignored_kill", kill_cnt, 0);
        chk("p_done_ignored_pass", pass_cnt, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("p_out_released", out_valid, 0);

        // Same fragment killed
        set_frag(2'd1, 2'd2, 8'h40, 16'hBEEF);
        step();
        frag_valid = 1'b0;
        run_frag(2'd1, 2'd2, 8'h40, 16'hBEEF, 1'b0, "kill");
        step();
        step();
        chk("idle_after_kill", zb_start, 0);
        chk("idle_after_kill_out", out_valid, 0);

        // Back-pressure: FSM parked in S_WAIT, burst of five pushes
        set_frag(2'd3, 2'd1, 8'h30, 16'h3030);
        step();
        frag_valid = 1'b0;
        wait_start("bp_f0");
        step();
        for (int i = 1; i <= 5; i++) begin
            set_frag(2'(i), 2'(i + 1), 8'(i * 16), 16'(16'hA000 + i));
            chk($sformatf("bp_ready_%0d", i), frag_ready, (i <= 4) ? 1 : 0);
            step();
        end
        frag_valid = 1'b0;
        chk("bp_ready_full", frag_ready, 0);
        chk("bp_hold_stable", zb_x, 3);
        chk("bp_hold_stable_z", zb_z, 8'h30);
        zb_done = 1'b1;
        zb_pass = 1'b1;
        step();
        exp_pass++;
        zb_done = 1'b0;
        zb_pass = 1'b0;
        chk("bp_f0_out_x", out_x, 3);
        chk("bp_f0_out_col", out_color, 16'h3030);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            run_frag(2'(i), 2'(i + 1), 8'(i * 16), 16'(16'hA000 + i), (i % 2) == 1,
                     $sformatf("bp_f%0d", i));
        end
        step();
        step();
        step();
        chk("bp_no_fifth", zb_start, 0);
        chk("bp_ready_again", frag_ready, 1);

        // Flush barrier
        set_frag(2'd0, 2'd3, 8'h05, 16'h1111);
        step();
        set_frag(2'd2, 2'd0, 8'h06, 16'h2222);
        flush_req = 1'b1;
        chk("fl_ready_pre", frag_ready, 1);
        step();
        frag_valid = 1'b0;
        flush_req  = 1'b0;
        chk("fl_ready_pending", frag_ready, 0);
        run_frag(2'd0, 2'd3, 8'h05, 16'h1111, 1'b1, "fl_a");
        chk("fl_ready_mid", frag_ready, 0);
        flush_req = 1'b1;
        run_frag(2'd2, 2'd0, 8'h06, 16'h2222, 1'b0, "fl_b");
        flush_req = 1'b0;
        chk("fl_ready_after_b", frag_ready, 0);
        wait_start("fl_cmd");
        chk("fl_zb_flush", zb_flush, 1);
        chk("fl_ack_early", flush_ack, 0);
        step();
        chk("fl_start_1cyc", zb_start, 0);
        chk("fl_flush_1cyc", zb_flush, 0);
        step();
        chk("fl_wait_ack", flush_ack, 0);
        chk("fl_wait_ready", frag_ready, 0);
        zb_done = 1'b1;
        step();
        zb_done = 1'b0;
        chk("fl_ack", flush_ack, 1);
        chk("fl_ready_at_ack", frag_ready, 1);
        step();
        chk("fl_ack_single", flush_ack, 0);
        chk("fl_no_restart", zb_start, 0);
        chk("fl_pass_cnt", pass_cnt, exp_pass);
        chk("fl_kill_cnt", kill_cnt, exp_kill);

        // Stalled output while the queue fills
        set_frag(2'd1, 2'd1, 8'h77, 16'hC0DE);
        step();
        frag_valid = 1'b0;
        wait_start("st");
        step();
        zb_done = 1'b1;
        zb_pass = 1'b1;
        step();
        exp_pass++;
        zb_done = 1'b0;
        zb_pass = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("st_valid_%0d", k), out_valid, 1);
            chk($sformatf("st_x_%0d", k), out_x, 1);
            chk($sformatf("st_y_%0d", k), out_y, 1);
            chk($sformatf("st_col_%0d", k), out_color, 16'hC0DE);
            if (k < 5) begin
                set_frag(2'(k), 2'(3 - k), 8'(8'h80 + k), 16'(16'h5000 + k));
                chk($sformatf("st_ready_%0d", k), frag_ready, (k < 4) ? 1 : 0);
            end else begin
                frag_valid = 1'b0;
            end
            step();
        end
        frag_valid = 1'b0;
        chk("st_full", frag_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("st_released", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            run_frag(2'(k), 2'(3 - k), 8'(8'h80 + k), 16'(16'h5000 + k), 1'b0,
                     $sformatf("st_q%0d", k));
        end

        // Reset while a test is in flight
        set_frag(2'd2, 2'd2, 8'h99, 16'h9999);
        step();
        frag_valid = 1'b0;
        wait_start("ra");
        step();
        rst = 1'b1;
        step();
        chk("ra_ready", frag_ready, 0);
        chk("ra_start", zb_start, 0);
        chk("ra_flush", zb_flush, 0);
        chk("ra_ack", flush_ack, 0);
        chk("ra_out_valid", out_valid, 0);
        chk("ra_pass_cnt", pass_cnt, 0);
        chk("ra_kill_cnt", kill_cnt, 0);
        chk("ra_zb_x", zb_x, 0);
        chk("ra_zb_z", zb_z, 0);
        chk("ra_out_x", out_x, 0);
        chk("ra_out_col", out_color, 0);
        zb_done = 1'b1;
        zb_pass = 1'b1;
        step();
        zb_done = 1'b0;
        zb_pass = 1'b0;
        rst = 1'b0;
        chk("ra_ready_fall", frag_ready, 0);
        step();
        chk("ra_ready_rise", frag_ready, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ra_no_out_%0d", k), out_valid, 0);
            chk($sformatf("ra_no_start_%0d", k), zb_start, 0);
            step();
        end
        chk("ra_pass_final", pass_cnt, 0);
        chk("ra_kill_final", kill_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
